// File: rtl/fft_sample_loader.sv
// Input-side writer for the FFT ping-pong RAM: pairs up incoming real samples
// and writes them to bit-reversed addresses, then hands the frame to the FFT.
module fft_sample_loader #(
  parameter int unsigned bit_width = 16,
  parameter int unsigned N         = 512,
  parameter int unsigned M         = 9
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        restart,
  input  logic                        sample_valid,
  input  logic signed [bit_width-1:0] sample,
  output logic                        sample_ready,
  output logic                        we,
  output logic [M-1:0]                adr_a,
  output logic [M-1:0]                adr_b,
  output logic [2*bit_width-1:0]      wd_a,
  output logic [2*bit_width-1:0]      wd_b,
  output logic                        frame_ready,
  input  logic                        frame_ack
);

  localparam int unsigned DW       = 2 * bit_width;
  localparam logic [M-1:0] LAST_IDX = M'(N - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t               state, state_next;
  logic [M-1:0]         idx, idx_next;
  logic [bit_width-1:0] hold, hold_next;
  logic                 we_next;
  logic [M-1:0]         adr_a_next, adr_b_next;
  logic [DW-1:0]        wd_a_next, wd_b_next;
  logic                 frame_ready_next;
  logic                 accept;
  logic [M-1:0]         pair_base;

  function automatic logic [M-1:0] bitrev(input logic [M-1:0] x);
    logic [M-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < M; i++) begin
      r[i] = x[M-1-i];
    end
    return r;
  endfunction

  // Ready is combinational; held low while in reset so every output reads 0.
  assign sample_ready = (state == FILL) && !restart && reset_n;
  assign accept       = sample_valid && sample_ready;
  assign pair_base    = {idx[M-1:1], 1'b0};

  // Next-state and registered-output decode; restart > frame_ack > accept.
  always_comb begin
    state_next       = state;
    idx_next         = idx;
    hold_next        = hold;
    we_next          = 1'b0;
    adr_a_next       = adr_a;
    adr_b_next       = adr_b;
    wd_a_next        = wd_a;
    wd_b_next        = wd_b;
    frame_ready_next = frame_ready;

    if (restart) begin
      state_next       = FILL;
      idx_next         = '0;
      hold_next        = '0;
      frame_ready_next = 1'b0;
    end else begin
      case (state)
        FULL: begin
          if (frame_ack) begin
            state_next       = FILL;
            frame_ready_next = 1'b0;
          end else begin
            frame_ready_next = 1'b1;
          end
        end
        default: begin
          frame_ready_next = 1'b0;
          if (accept) begin
            idx_next = idx + M'(1);
            if (!idx[0]) begin
              hold_next = sample;
            end else begin
              we_next    = 1'b1;
              adr_a_next = bitrev(pair_base);
              adr_b_next = bitrev(idx);
              wd_a_next  = {hold, bit_width'(0)};
              wd_b_next  = {sample, bit_width'(0)};
            end
            if (idx == LAST_IDX) begin
              state_next = FULL;
            end
          end
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FILL;
      idx         <= '0;
      hold        <= '0;
      we          <= 1'b0;
      adr_a       <= '0;
      adr_b       <= '0;
      wd_a        <= '0;
      wd_b        <= '0;
      frame_ready <= 1'b0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      hold        <= hold_next;
      we          <= we_next;
      adr_a       <= adr_a_next;
      adr_b       <= adr_b_next;
      wd_a        <= wd_a_next;
      wd_b        <= wd_b_next;
      frame_ready <= frame_ready_next;
    end
  end

endmodule

// File: doc/fft_sample_loader.md
# fft_sample_loader

Input-side writer for the 512-point FFT ping-pong RAM. Accepts a stream of real signed audio samples over a valid/ready handshake and writes each frame into one RAM bank in bit-reversed address order, so the FFT stages read natural-order data. Samples are packed as `{re, im}` with `im = 0`. Writes use both RAM write ports, one sample pair per write cycle. After a full frame is written, the block hands it to the FFT controller and waits for acknowledge.

## Interface
Parameters:
- `bit_width`, 16, width of each of the Re and Im components
- `N`, 512, FFT length and samples per frame
- `M`, log2(N) = 9, address width

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `restart`  in  1  synchronous frame abort; discards the current partial frame
- `sample_valid`  in  1  `sample` holds a valid sample
- `sample`  in  bit_width  signed real sample
- `sample_ready`  out  1  block can accept a sample this cycle
- `we`  out  1  RAM write enable, covering both ports
- `adr_a`, `adr_b`  out  M  RAM write addresses
- `wd_a`, `wd_b`  out  2*bit_width  RAM write data, `{re, im}`
- `frame_ready`  out  1  a complete frame is in RAM
- `frame_ack`  in  1  FFT controller has taken the frame

## Operation
- States:
  - FILL: accepting samples.
  - FULL: frame complete; waiting for `frame_ack`.
- Reset (asynchronous, `reset_n` = 0) forces:
  - state = FILL, sample index `idx` = 0, hold register = 0
  - `we` = 0, `adr_a` = `adr_b` = 0, `wd_a` = `wd_b` = 0
  - `frame_ready` = 0
  - `sample_ready` = 1 from the first cycle after release
- `sample_ready` = (state == FILL) && !`restart`. It is decoded combinationally from state.
- Accept condition: `sample_valid && sample_ready`. On each accept, `idx` increments.
- Even `idx`: the sample is latched into the hold register. No write occurs.
- Odd `idx`: on the next cycle, the registered outputs present:
  - `we` = 1
  - `adr_a` = bitrev(`idx` - 1), `wd_a` = {hold, 0}
  - `adr_b` = bitrev(`idx`), `wd_b` = {sample, 0}
- bitrev reverses all M bits of the index. Data is written unscaled; im is all zeros.
- `we` is a one-cycle pulse per pair. Address and data outputs hold their last values when `we` = 0.
- Accepting `idx` = N-1 moves the state to FULL. `idx` wraps to 0.
- FULL:
  - `frame_ready` = 1, starting the cycle after the final write pulse.
  - `sample_ready` = 0.
  - `frame_ack` high: next cycle, `frame_ready` = 0, state = FILL, `sample_ready` = 1.
- `frame_ack` is ignored while in FILL.
- `restart` (any state) on the next cycle gives:
  - state = FILL, `idx` = 0, hold discarded
  - `frame_ready` = 0, `we` = 0 (any pair whose final sample was accepted the same cycle is dropped)
- Priority: `reset_n` > `restart` > `frame_ack` > sample accept.

## Timing
- Accept of an odd-index sample at cycle t: `we` = 1 with that pair at t+1.
- Accept of sample N-1 at cycle t:
  - t+1: `we` = 1 with the last pair; `sample_ready` = 0 (state FULL).
  - t+2 onward: `frame_ready` = 1.
- `frame_ack` sampled at cycle u: `frame_ready` = 0 and `sample_ready` = 1 at u+1.
- Back-to-back samples at one per cycle: full throughput, one write per two cycles, `we` never asserted on consecutive cycles.
- Gaps in `sample_valid`: no effect beyond stretching. The hold register persists indefinitely.
- Reset mid-frame: outputs reach reset values immediately, without waiting for a clock edge. The partial frame is lost.

## Test plan
- Stream `sample` = k for k = 0..511, one per cycle:
  - 256 `we` pulses.
  - First pulse: `adr_a` = 0, `wd_a` = 0x00000000, `adr_b` = 256, `wd_b` = 0x00010000.
  - Last pulse: `adr_a` = 255, `adr_b` = 511, `wd_b` = 0x01FF0000.
  - `frame_ready` = 1 two cycles after the last accept.
- Samples 2 and 3 = -1 (0xFFFF): the write has `adr_a` = 128, `adr_b` = 384, and both data words = 0xFFFF0000.
- Hold `sample_valid` = 1 while in FULL for 20 cycles: no accepts and no `we`. Then pulse `frame_ack`: the next accepted sample is index 0 and goes to `adr_a` = 0.
- Present sample 0, then idle 10 cycles, then present sample 1: the single `we` pulse occurs one cycle after sample 1 is accepted, with the correct hold data.
- Pulse `restart` right after sample 100 is accepted: no write for samples 100 or 101. The next two samples write to `adr_a` = 0 and `adr_b` = 256.
- Assert `reset_n` low asynchronously after 300 samples: all outputs are 0 immediately and `frame_ready` = 0. After release, a full frame completes normally.
